// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
//   state_t  : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   owner_t  : which port a grant goes to (OWN_I, OWN_D)
//   BE_ALL   : full byte-enable mask at the default data width
//   AW_DEF / DW_DEF : default address / data widths
//   STREAK_W : width of the fetch-starvation streak counter (holds 0..15)
package mem_arb_pkg;

  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;
  localparam int STREAK_W = 4;

  localparam logic [DW_DEF/8-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant decision for the memory port arbiter.
//   i_req, d_req   : raw port requests
//   excl_i, excl_d : port being acked this cycle; its request is treated as done
//   streak         : consecutive D grants issued while a fetch was waiting
//   gnt_vld        : some candidate exists
//   gnt_own        : winning port (meaningful only when gnt_vld = 1)
//   i_cand         : fetch is a live candidate this cycle (drives streak update)
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic                excl_i,
  input  logic                excl_d,
  input  logic [STREAK_W-1:0] streak,
  output logic                gnt_vld,
  output owner_t              gnt_own,
  output logic                i_cand
);

  logic d_cand;
  logic starved;

  always_comb begin
    i_cand  = i_req & ~excl_i;
    d_cand  = d_req & ~excl_d;
    starved = i_cand && (streak == STREAK_W'(STARVE_LIM));
    gnt_vld = i_cand | d_cand;
    // Data has priority unless fetch has waited out its streak allowance.
    gnt_own = (d_cand && !starved) ? OWN_D : OWN_I;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between the instruction-fetch
// (I) port and the data-access (D) port. One request is latched at grant and
// held on the mem_* bus until mem_rdy; the owning port then gets a
// combinational ack with mem_rdata passed straight through.
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_req/i_addr          : fetch request, held until i_ack
//   i_ack/i_rdata         : fetch completion strobe and data (0 when not acked)
//   d_req/d_we/d_addr/d_wdata/d_be : data request, held until d_ack
//   d_ack/d_rdata         : data completion strobe and data (0 when not acked)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : memory access, stable per access
//   mem_rdy/mem_rdata     : memory completion and read data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_rdy,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                lat_we;
  logic [AW-1:0]       lat_addr;
  logic [DW-1:0]       lat_wdata;
  logic [BW-1:0]       lat_be;

  logic                done;
  logic                i_done;
  logic                d_done;
  logic                decide;
  logic                gnt_vld;
  owner_t              gnt_own;
  logic                i_cand;
  logic [STREAK_W-1:0] streak_inc;

  // mem_rdy only counts while an access is outstanding; in IDLE it is ignored.
  assign done   = (state != IDLE) && mem_rdy;
  assign i_done = done && (state == BUSY_I);
  assign d_done = done && (state == BUSY_D);
  // Re-arbitrating on the completion cycle gives the zero-bubble handover.
  assign decide = (state == IDLE) || done;

  assign streak_inc = (streak == STREAK_W'(STARVE_LIM)) ? streak : streak + 1'b1;

  arb_pick #(
    .STARVE_LIM(STARVE_LIM)
  ) u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .excl_i (i_done),
    .excl_d (d_done),
    .streak (streak),
    .gnt_vld(gnt_vld),
    .gnt_own(gnt_own),
    .i_cand (i_cand)
  );

  // FSM, request latch and streak counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (decide) begin
      if (!gnt_vld) begin
        state <= IDLE;
      end else if (gnt_own == OWN_D) begin
        state     <= BUSY_D;
        lat_we    <= d_we;
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata;
        lat_be    <= d_be;
        // Only D grants that bypass a waiting fetch count toward starvation.
        streak    <= i_cand ? streak_inc : '0;
      end else begin
        state     <= BUSY_I;
        lat_we    <= 1'b0;
        lat_addr  <= i_addr;
        lat_wdata <= '0;
        lat_be    <= '1;
        streak    <= '0;
      end
    end
  end

  // Memory side comes straight from registers, so it is glitch-free per access.
  assign mem_req   = (state != IDLE);
  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_be    = lat_be;

  assign i_ack   = i_done;
  assign d_ack   = d_done;
  assign i_rdata = i_done ? mem_rdata : '0;
  assign d_rdata = d_done ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_rdy;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_rdy  (mem_rdy),
    .mem_rdata(mem_rdata)
  );

  // Reference model: who owns the memory (0 none, 1 fetch, 2 data), how many
  // D grants have bypassed a waiting fetch, and the access currently on the bus.
  int          m_owner;
  int          m_streak;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [3:0]  m_be;

  task automatic model_reset();
    m_owner  = 0;
    m_streak = 0;
    m_addr   = '0;
    m_wdata  = '0;
    m_we     = 1'b0;
    m_be     = '0;
  endtask

  // Applies the arbitration rules to the inputs present just before an edge.
  task automatic model_step();
    bit fin, ci, cd;
    fin = (m_owner != 0) && mem_rdy;
    ci  = i_req && !(fin && m_owner == 1);
    cd  = d_req && !(fin && m_owner == 2);
    if (m_owner == 0 || fin) begin
      if (cd && !(ci && m_streak == LIM)) begin
        m_owner  = 2;
        m_streak = ci ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
        m_addr = d_addr; m_wdata = d_wdata; m_we = d_we; m_be = d_be;
      end else if (ci) begin
        m_owner  = 1;
        m_streak = 0;
        m_addr = i_addr; m_wdata = '0; m_we = 1'b0; m_be = 4'hF;
      end else begin
        m_owner = 0;
      end
    end
  endtask

  // Advance one clock: model and DUT see the same inputs; returns at edge+1.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_rdy = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    model_reset();
    repeat (2) @(posedge clk);
    #4;
    total++; if ({mem_req, mem_we, i_ack, d_ack} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", {mem_req, mem_we, i_ack, d_ack}); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
    total++; if (mem_be !== 4'h0) begin bad++; $display("FAIL reset_mem_be got=%h want=0", mem_be); end
    total++; if ({i_rdata, d_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h want=0", i_rdata, d_rdata); end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rdy = 1'b0; mem_rdata = '0;
    tick();
  endtask

  task automatic test_single_fetch();
    i_req = 1'b1; i_addr = 32'h100;
    tick();
    #4;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_mem_req got=%b want=1", mem_req); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL fetch_addr got=%h want=100", mem_addr); end
    total++; if ({mem_we, mem_be} !== 5'b0_1111) begin bad++; $display("FAIL fetch_we_be got=%b want=01111", {mem_we, mem_be}); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL fetch_wdata got=%h want=0", mem_wdata); end
    total++; if (i_ack !== 1'b0) begin bad++; $display("FAIL fetch_early_ack got=%b want=0", i_ack); end
    tick();
    mem_rdy = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #4;
    total++; if ({i_ack, d_ack} !== 2'b10) begin bad++; $display("FAIL fetch_ack got=%b want=10", {i_ack, d_ack}); end
    total++; if (i_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_rdata got=%h want=deadbeef", i_rdata); end
    tick();
    i_req = 1'b0; mem_rdy = 1'b0;
    #4;
    total++; if ({mem_req, i_ack} !== 2'b00) begin bad++; $display("FAIL fetch_after got=%b want=00", {mem_req, i_ack}); end
    total++; if (i_rdata !== 32'h0) begin bad++; $display("FAIL fetch_rdata_idle got=%h want=0", i_rdata); end
    tick();
  endtask

  task automatic test_simultaneous();
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_be = 4'h3;
    tick();
    #4;
    total++; if ({mem_req, mem_we, mem_be} !== 6'b11_0011) begin bad++; $display("FAIL simul_d_first got=%b want=110011", {mem_req, mem_we, mem_be}); end
    total++; if (mem_addr !== 32'h200) begin bad++; $display("FAIL simul_d_addr got=%h want=200", mem_addr); end
    total++; if (mem_wdata !== 32'h1234_5678) begin bad++; $display("FAIL simul_d_wdata got=%h want=12345678", mem_wdata); end
    tick();
    mem_rdy = 1'b1;
    #4;
    total++; if ({d_ack, i_ack} !== 2'b10) begin bad++; $display("FAIL simul_d_ack got=%b want=10", {d_ack, i_ack}); end
    tick();
    d_req = 1'b0; mem_rdy = 1'b0;
    #4;
    total++; if ({mem_req, mem_we, mem_be} !== 6'b10_1111) begin bad++; $display("FAIL simul_i_next got=%b want=101111", {mem_req, mem_we, mem_be}); end
    total++; if (mem_addr !== 32'h300) begin bad++; $display("FAIL simul_i_addr got=%h want=300", mem_addr); end
    tick();
    mem_rdy = 1'b1; mem_rdata = 32'h0BAD_F00D;
    #4;
    total++; if ({i_ack, i_rdata} !== {1'b1, 32'h0BAD_F00D}) begin bad++; $display("FAIL simul_i_ack got=%b/%h want=1/0badf00d", i_ack, i_rdata); end
    tick();
    i_req = 1'b0; mem_rdy = 1'b0;
    tick();
  endtask

  // Both ports keep requesting and memory answers every cycle: fetch must
  // never wait behind more than LIM data accesses.
  task automatic test_starvation();
    int d_run, i_cnt, d_cnt;
    bit pi, pd, ea, eb;
    d_run = 0; i_cnt = 0; d_cnt = 0;
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h55; d_be = 4'hF;
    mem_rdy = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      #4;
      ea = (m_owner == 1); eb = (m_owner == 2);
      total++; if ({i_ack, d_ack} !== {ea, eb}) begin bad++; $display("FAIL starve_ack k=%0d got=%b want=%b", k, {i_ack, d_ack}, {ea, eb}); end
      total++; if (mem_addr !== m_addr) begin bad++; $display("FAIL starve_addr k=%0d got=%h want=%h", k, mem_addr, m_addr); end
      if (eb) begin d_run++; d_cnt++; end
      if (ea) begin d_run = 0; i_cnt++; end
      total++; if (d_run > LIM) begin bad++; $display("FAIL starve_run k=%0d got=%0d want<=%0d", k, d_run, LIM); end
      pi = ea; pd = eb;
      tick();
      if (pi) i_addr = i_addr + 4;
      if (pd) d_addr = d_addr + 4;
    end
    total++; if (i_cnt < 16 / (LIM + 1)) begin bad++; $display("FAIL starve_i_served got=%0d want>=%0d", i_cnt, 16 / (LIM + 1)); end
    total++; if (d_cnt == 0) begin bad++; $display("FAIL starve_d_served got=0 want>0"); end
    i_req = 1'b0; d_req = 1'b0; mem_rdy = 1'b0;
    tick(); tick();
  endtask

  task automatic test_same_port_b2b();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF;
    tick();
    mem_rdy = 1'b1; mem_rdata = 32'hA5A5_0001;
    #4;
    total++; if ({d_ack, d_rdata} !== {1'b1, 32'hA5A5_0001}) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/a5a50001", d_ack, d_rdata); end
    tick();
    d_addr = 32'h404; mem_rdata = 32'hA5A5_0002;
    #4;
    total++; if ({mem_req, d_ack} !== 2'b00) begin bad++; $display("FAIL b2b_bubble got=%b want=00", {mem_req, d_ack}); end
    tick();
    #4;
    total++; if ({mem_req, mem_addr} !== {1'b1, 32'h404}) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/404", mem_req, mem_addr); end
    total++; if ({d_ack, d_rdata} !== {1'b1, 32'hA5A5_0002}) begin bad++; $display("FAIL b2b_second_ack got=%b/%h want=1/a5a50002", d_ack, d_rdata); end
    tick();
    d_req = 1'b0; mem_rdy = 1'b0;
    #4;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b want=0", mem_req); end
    tick();
  endtask

  task automatic test_async_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h77; d_be = 4'hC;
    tick();
    #1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL arst_busy got=%b want=1", mem_req); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({mem_req, d_ack, mem_we} !== 3'b000) begin bad++; $display("FAIL arst_drop got=%b want=000", {mem_req, d_ack, mem_we}); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL arst_addr got=%h want=0", mem_addr); end
    model_reset();
    d_req = 1'b0; mem_rdy = 1'b1;
    #1;
    total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL arst_no_ack got=%b want=0", d_ack); end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rdy = 1'b0;
    i_req = 1'b1; i_addr = 32'h600;
    tick();
    #4;
    total++; if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin bad++; $display("FAIL arst_after got=%b/%h want=1/600", mem_req, mem_addr); end
    tick();
    mem_rdy = 1'b1; mem_rdata = 32'hCAFE_0600;
    #4;
    total++; if ({i_ack, i_rdata} !== {1'b1, 32'hCAFE_0600}) begin bad++; $display("FAIL arst_after_ack got=%b/%h want=1/cafe0600", i_ack, i_rdata); end
    tick();
    i_req = 1'b0; mem_rdy = 1'b0;
    tick();
  endtask

  task automatic test_stray_rdy();
    mem_rdy = 1'b1; mem_rdata = 32'h0000_0123;
    #4;
    total++; if ({mem_req, i_ack, d_ack} !== 3'b000) begin bad++; $display("FAIL stray_ack got=%b want=000", {mem_req, i_ack, d_ack}); end
    total++; if ({i_rdata, d_rdata} !== 64'h0) begin bad++; $display("FAIL stray_rdata got=%h/%h want=0", i_rdata, d_rdata); end
    tick();
    #4;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL stray_state got=%b want=0", mem_req); end
    tick();
    i_req = 1'b1; i_addr = 32'h700;
    tick();
    #4;
    total++; if ({mem_req, i_ack, mem_addr} !== {2'b11, 32'h700}) begin bad++; $display("FAIL stray_min_rt got=%b%b/%h want=11/700", mem_req, i_ack, mem_addr); end
    tick();
    i_req = 1'b0; mem_rdy = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit pi, pd, ea, eb, er;
    pi = 0; pd = 0;
    for (int k = 0; k < 600; k++) begin
      if (!i_req || pi) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req || pd) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = ($urandom_range(0, 1) != 0);
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(1, 15));
      end
      mem_rdy   = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      #4;
      er = (m_owner != 0);
      ea = (m_owner == 1) && mem_rdy;
      eb = (m_owner == 2) && mem_rdy;
      total++; if ({mem_req, i_ack, d_ack} !== {er, ea, eb}) begin bad++; $display("FAIL rand_ctrl k=%0d got=%b want=%b", k, {mem_req, i_ack, d_ack}, {er, ea, eb}); end
      total++; if (i_rdata !== (ea ? mem_rdata : 32'h0)) begin bad++; $display("FAIL rand_i_rdata k=%0d got=%h want=%h", k, i_rdata, ea ? mem_rdata : 32'h0); end
      total++; if (d_rdata !== (eb ? mem_rdata : 32'h0)) begin bad++; $display("FAIL rand_d_rdata k=%0d got=%h want=%h", k, d_rdata, eb ? mem_rdata : 32'h0); end
      if (er) begin
        total++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== {m_we, m_be, m_addr, m_wdata}) begin
          bad++; $display("FAIL rand_fields k=%0d got=%b/%h/%h/%h want=%b/%h/%h/%h", k, mem_we, mem_be, mem_addr, mem_wdata, m_we, m_be, m_addr, m_wdata);
        end
      end
      pi = ea; pd = eb;
      tick();
    end
    i_req = 1'b0; d_req = 1'b0; mem_rdy = 1'b1;
    repeat (4) tick();
    mem_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_same_port_b2b();
    test_async_reset();
    test_stray_rdy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
